spi_bus_arbiter: RTL and testbench

- Shares the single SPI byte-read engine (start/addr/busy/done/data handshake) between two requesters: R0 (CPU instruction fetch) and R1 (data/load port).
- Sits between the CPU fetch FSM and the SPI read engine.
- Round-robin arbitration, with a bounded lock so R0 can fetch opcode and operand back-to-back.
- Registered outputs throughout.

---
 rtl/spi_arb_pkg.sv | 17 +
 rtl/spi_arb_watchdog.sv | 30 +++
 rtl/spi_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared state encodings, requester IDs and defaults for the SPI bus arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam logic       REQ_R0             = 1'b0;
  localparam logic       REQ_R1             = 1'b1;
  localparam logic [7:0] ERR_DATA           = 8'hFF;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam int unsigned DEF_MAX_LOCK       = 4;

endpackage

// File: rtl/spi_arb_watchdog.sv
// Loadable down-counter; expired is high during the last enabled count before zero.
module spi_arb_watchdog #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && (cnt == W'(1));

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI byte-read engine between R0 (fetch) and R1 (data).
// Define SPI_ARB_TIMEOUT_EN to add the WAIT watchdog, sticky err flag and DRAIN state.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned MAX_LOCK       = DEF_MAX_LOCK,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_lock,
  output logic              r0_ack,
  output logic              r0_done,
  output logic [7:0]        r0_data,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_lock,
  output logic              r1_ack,
  output logic              r1_done,
  output logic [7:0]        r1_data,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_busy,
  input  logic              eng_done,
  input  logic [7:0]        eng_data,
  output logic              owner,
  output logic              err
);

  localparam int unsigned LOCK_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

  arb_state_t        state, state_nxt;
  logic              grant, grant_id, relock, timeout;
  logic              own_req, oth_req, lock_ok;
  logic              lock_req;
  logic [LOCK_W-1:0] lock_cnt;
  logic              take_data;
  logic [7:0]        done_data;
  logic              ack0_d, ack1_d, start_d, done0_d, done1_d;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned WD_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic wd_expired;
`endif

  // Lock is refused only on the last allowed grant while the other side waits.
  assign own_req = owner ? r1_req : r0_req;
  assign oth_req = owner ? r0_req : r1_req;
  assign lock_ok = lock_req && own_req && !(oth_req && (lock_cnt == LOCK_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_id  = owner;
    relock    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if ((r0_req || r1_req) && !eng_busy) begin
          grant     = 1'b1;
          grant_id  = (r0_req && r1_req) ? ~owner : r1_req;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (eng_done) begin
          if (lock_ok) begin
            grant     = 1'b1;
            grant_id  = owner;
            relock    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          timeout   = 1'b1;
          state_nxt = DRAIN;
        end
`endif
      end
      DRAIN: begin
`ifdef SPI_ARB_TIMEOUT_EN
        if (!eng_busy) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    take_data = ((state == WAIT) && eng_done) || timeout;
    done_data = timeout ? ERR_DATA : eng_data;
    ack0_d    = grant && (grant_id == REQ_R0);
    ack1_d    = grant && (grant_id == REQ_R1);
    start_d   = (state == ISSUE);
    done0_d   = take_data && (owner == REQ_R0);
    done1_d   = take_data && (owner == REQ_R1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_ack    <= 1'b0;
      r1_ack    <= 1'b0;
      eng_start <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      r0_data   <= '0;
      r1_data   <= '0;
      eng_addr  <= '0;
      owner     <= REQ_R1;
      lock_req  <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      r0_ack    <= ack0_d;
      r1_ack    <= ack1_d;
      eng_start <= start_d;
      r0_done   <= done0_d;
      r1_done   <= done1_d;
      if (done0_d) r0_data <= done_data;
      if (done1_d) r1_data <= done_data;
      if (grant) begin
        owner    <= grant_id;
        eng_addr <= grant_id ? r1_addr : r0_addr;
        lock_req <= grant_id ? r1_lock : r0_lock;
      end
      if (relock) begin
        if (lock_cnt != LOCK_LAST) lock_cnt <= lock_cnt + 1'b1;
      end else if ((state_nxt == IDLE) || timeout) begin
        lock_cnt <= '0;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  spi_arb_watchdog #(
    .W (WD_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == IDLE),
    .load     (state == ISSUE),
    .en       (state == WAIT),
    .load_val (WD_W'(TIMEOUT_CYCLES)),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (timeout) err <= 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: requester/engine models, event log, vector table
// plus hand sequences for latency, lock, fairness, reset and (optionally) timeout.
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

  localparam int TO_CYC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic [15:0] r0_addr = '0, r1_addr = '0;
  logic        r0_lock = 1'b0, r1_lock = 1'b0;
  logic        r0_ack, r1_ack, r0_done, r1_done;
  logic [7:0]  r0_data, r1_data;
  logic        eng_start, eng_busy, owner, err;
  logic [15:0] eng_addr;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_data;

  spi_bus_arbiter #(
    .ADDR_W         (16),
    .MAX_LOCK       (4),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0_req    (r0_req),
    .r0_addr   (r0_addr),
    .r0_lock   (r0_lock),
    .r0_ack    (r0_ack),
    .r0_done   (r0_done),
    .r0_data   (r0_data),
    .r1_req    (r1_req),
    .r1_addr   (r1_addr),
    .r1_lock   (r1_lock),
    .r1_ack    (r1_ack),
    .r1_done   (r1_done),
    .r1_data   (r1_data),
    .eng_start (eng_start),
    .eng_addr  (eng_addr),
    .eng_busy  (eng_busy),
    .eng_done  (eng_done),
    .eng_data  (eng_data),
    .owner     (owner),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Requester models: each pending entry is presented until acked.
  typedef struct {
    logic [15:0] a;
    logic        l;
  } rq_t;
  rq_t q0[$];
  rq_t q1[$];
  int  t_req0 = 0;

  task automatic push0(input logic [15:0] a, input logic l);
    rq_t e;
    e.a = a; e.l = l;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [15:0] a, input logic l);
    rq_t e;
    e.a = a; e.l = l;
    q1.push_back(e);
  endtask

  always @(negedge clk) begin
    if (r0_ack && q0.size() > 0) void'(q0.pop_front());
    if (q0.size() > 0) begin
      if (!r0_req) t_req0 = cyc;
      r0_req = 1'b1; r0_addr = q0[0].a; r0_lock = q0[0].l;
    end else begin
      r0_req = 1'b0; r0_lock = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (r1_ack && q1.size() > 0) void'(q1.pop_front());
    if (q1.size() > 0) begin
      r1_req = 1'b1; r1_addr = q1[0].a; r1_lock = q1[0].l;
    end else begin
      r1_req = 1'b0; r1_lock = 1'b0;
    end
  end

  // Engine model: busy for eng_lat cycles after start, then a done pulse (unless hung).
  int         eng_lat = 4;
  logic [7:0] eng_rdata = 8'h00;
  logic       eng_hang = 1'b0;
  logic       eng_busy_m = 1'b0;
  logic       force_busy = 1'b0;
  int         eng_cnt = 0;
  int         t_engdone = 0;

  always @(negedge clk) begin
    eng_done = 1'b0;
    if (eng_start) begin
      eng_busy_m = 1'b1;
      eng_cnt    = eng_lat;
    end else if (eng_busy_m) begin
      eng_cnt--;
      if (eng_cnt <= 0) begin
        eng_busy_m = 1'b0;
        if (!eng_hang) begin
          eng_done  = 1'b1;
          t_engdone = cyc;
        end
      end
    end
  end

  assign eng_busy = eng_busy_m | force_busy;
  assign eng_data = eng_done ? eng_rdata : 8'h3C;

  // Event log of DUT output pulses.
  int ack0_t[$], ack1_t[$], start_t[$], start_a[$];
  int done0_t[$], done0_d[$], done1_t[$], done1_d[$];

  always @(negedge clk) begin
    if (r0_ack) ack0_t.push_back(cyc);
    if (r1_ack) ack1_t.push_back(cyc);
    if (eng_start) begin start_t.push_back(cyc); start_a.push_back(int'(eng_addr)); end
    if (r0_done) begin done0_t.push_back(cyc); done0_d.push_back(int'(r0_data)); end
    if (r1_done) begin done1_t.push_back(cyc); done1_d.push_back(int'(r1_data)); end
  end

  task automatic clr_log();
    ack0_t.delete(); ack1_t.delete(); start_t.delete(); start_a.delete();
    done0_t.delete(); done0_d.delete(); done1_t.delete(); done1_d.delete();
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic do_reset();
    q0.delete(); q1.delete();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  typedef struct {
    logic        p0;
    logic        p1;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [7:0]  d;
    logic        exp_id;
    logic [15:0] exp_addr;
  } vec_t;

  initial begin
    vec_t       vt[7];
    logic [7:0] md0, md1;
    int         exp_ml[7];
    int         t_rel, t_bf;

    // p0/p1 = new request pushed this step; a request left pending carries over.
    vt[0] = '{1'b1, 1'b1, 16'h1000, 16'h2000, 8'h11, REQ_R0, 16'h1000};
    vt[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 8'h22, REQ_R1, 16'h2000};
    vt[2] = '{1'b1, 1'b1, 16'h1001, 16'h2001, 8'h33, REQ_R0, 16'h1001};
    vt[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 8'h44, REQ_R1, 16'h2001};
    vt[4] = '{1'b0, 1'b1, 16'h0000, 16'h2002, 8'h55, REQ_R1, 16'h2002};
    vt[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 8'h00, REQ_R0, 16'hFFFF};
    vt[6] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 8'hFF, REQ_R1, 16'h0000};
    exp_ml = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h100, 32'h24, 32'h25};

    // Reset values
    repeat (2) tick();
    chk("rst_async_owner", owner, 1);
    do_reset();
    chk("rst_owner", owner, 1);
    chk("rst_eng_addr", eng_addr, 0);
    chk("rst_r0_data", r0_data, 0);
    chk("rst_r1_data", r1_data, 0);
    chk("rst_err", err, 0);
    chk("rst_pulses", {r0_ack, r1_ack, eng_start, r0_done, r1_done}, 0);

    // R0 alone: latency and data return
    clr_log();
    eng_lat = 20; eng_rdata = 8'hA5;
    push0(16'h0003, 1'b0);
    for (int k = 0; k < 80 && done0_t.size() == 0; k++) tick();
    chk("t1_ack_lat", qget(ack0_t, 0) - t_req0, 1);
    chk("t1_start_lat", qget(start_t, 0) - t_req0, 2);
    chk("t1_start_addr", qget(start_a, 0), 32'h0003);
    chk("t1_done_after_eng", qget(done0_t, 0) - t_engdone, 1);
    chk("t1_data", qget(done0_d, 0), 32'hA5);
    chk("t1_eng_addr_held", eng_addr, 16'h0003);
    repeat (3) tick();
    chk("t1_no_r1_done", done1_t.size(), 0);
    chk("t1_r0_data_held", r0_data, 8'hA5);

    // Table: arbitration from reset, alternation, single requesters, address extremes
    do_reset();
    md0 = '0; md1 = '0;
    eng_lat = 4;
    for (int i = 0; i < 7; i++) begin
      clr_log();
      eng_rdata = vt[i].d;
      if (vt[i].p0) push0(vt[i].a0, 1'b0);
      if (vt[i].p1) push1(vt[i].a1, 1'b0);
      for (int k = 0; k < 80 && (done0_t.size() + done1_t.size()) == 0; k++) tick();
      chk($sformatf("v%0d_ack_r0", i), ack0_t.size(), (vt[i].exp_id == REQ_R0) ? 1 : 0);
      chk($sformatf("v%0d_ack_r1", i), ack1_t.size(), (vt[i].exp_id == REQ_R1) ? 1 : 0);
      chk($sformatf("v%0d_addr", i), qget(start_a, 0), 32'(vt[i].exp_addr));
      chk($sformatf("v%0d_owner", i), owner, vt[i].exp_id);
      if (vt[i].exp_id == REQ_R0) begin
        chk($sformatf("v%0d_data", i), qget(done0_d, 0), 32'(vt[i].d));
        chk($sformatf("v%0d_other_done", i), done1_t.size(), 0);
        chk($sformatf("v%0d_other_data", i), r1_data, md1);
        md0 = vt[i].d;
      end else begin
        chk($sformatf("v%0d_data", i), qget(done1_d, 0), 32'(vt[i].d));
        chk($sformatf("v%0d_other_done", i), done0_t.size(), 0);
        chk($sformatf("v%0d_other_data", i), r0_data, md0);
        md1 = vt[i].d;
      end
    end
    repeat (4) tick();

    // Request withdrawn before acceptance
    clr_log();
    force_busy = 1'b1;
    push0(16'h0050, 1'b0);
    repeat (4) tick();
    q0.delete();
    repeat (2) tick();
    force_busy = 1'b0;
    repeat (6) tick();
    chk("drop_no_ack", ack0_t.size(), 0);
    chk("drop_no_start", start_t.size(), 0);

    // Locked back-to-back R0 reads, R1 idle (lock count saturates)
    clr_log();
    eng_lat = 3; eng_rdata = 8'h6B;
    for (int j = 0; j < 6; j++) push0(16'h0010 + 16'(j), (j < 5) ? 1'b1 : 1'b0);
    for (int k = 0; k < 300 && done0_t.size() < 6; k++) tick();
    chk("lock_done_cnt", done0_t.size(), 6);
    for (int j = 0; j < 6; j++)
      chk($sformatf("lock_addr%0d", j), qget(start_a, j), 32'h10 + j);
    for (int j = 0; j < 5; j++)
      chk($sformatf("lock_no_idle%0d", j), qget(ack0_t, j + 1), qget(done0_t, j));
    repeat (4) tick();

    // Lock bounded by MAX_LOCK while R1 waits
    clr_log();
    for (int j = 0; j < 6; j++) push0(16'h0020 + 16'(j), 1'b1);
    for (int k = 0; k < 40 && ack0_t.size() == 0; k++) tick();
    push1(16'h0100, 1'b0);
    for (int k = 0; k < 400 && start_t.size() < 7; k++) tick();
    for (int k = 0; k < 40 && done0_t.size() < 6; k++) tick();
    for (int j = 0; j < 7; j++)
      chk($sformatf("ml_addr%0d", j), qget(start_a, j), exp_ml[j]);
    chk("ml_r1_after_4", qget(ack1_t, 0), qget(done0_t, 3) + 1);
    chk("ml_r1_data", qget(done1_d, 0), 32'h6B);
    repeat (4) tick();

`ifdef SPI_ARB_TIMEOUT_EN
    // Engine hangs: watchdog returns ERR_DATA, then DRAIN until busy falls
    clr_log();
    eng_hang = 1'b1; eng_lat = 30;
    push0(16'h0040, 1'b0);
    for (int k = 0; k < 100 && done0_t.size() == 0; k++) tick();
    chk("to_data", qget(done0_d, 0), 32'hFF);
    chk("to_cycle", qget(done0_t, 0) - qget(start_t, 0), TO_CYC);
    chk("to_err", err, 1);
    push1(16'h0041, 1'b0);
    for (int k = 0; k < 60 && eng_busy_m; k++) tick();
    t_bf = cyc;
    eng_hang = 1'b0; eng_lat = 3; eng_rdata = 8'h77;
    chk("to_no_start_in_drain", start_t.size(), 1);
    for (int k = 0; k < 60 && done1_t.size() == 0; k++) tick();
    chk("to_next_start", qget(start_t, 1), t_bf + 3);
    chk("to_r1_data", qget(done1_d, 0), 32'h77);
    chk("to_err_sticky", err, 1);
    chk("to_r0_data_held", r0_data, 8'hFF);
    repeat (4) tick();
`endif

    // Reset during WAIT, late engine done after release
    clr_log();
    eng_lat = 11;
    push0(16'h0060, 1'b0);
    for (int k = 0; k < 40 && start_t.size() == 0; k++) tick();
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_eng_addr", eng_addr, 0);
    chk("mid_rst_owner", owner, 1);
    chk("mid_rst_r0_data", r0_data, 0);
    chk("mid_rst_err", err, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    t_rel = cyc;
    repeat (12) tick();
    chk("mid_late_done_seen", t_engdone - t_rel, 3);
    chk("mid_no_r0_done", done0_t.size(), 0);
    chk("mid_no_r1_done", done1_t.size(), 0);
    chk("mid_single_start", start_t.size(), 1);
    chk("mid_owner_idle", owner, 1);
    chk("mid_r0_data", r0_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
